// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage control-flow bundle: instruction operands in, redirect handshake,
// flush/stall, link write and status out.
interface branch_redirect_ctrl_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
);
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [6:0]        ex_opcode;
  logic [2:0]        ex_func3;
  logic [20:0]       ex_imm;
  logic [XLEN-1:0]   ex_rs1;
  logic [XLEN-1:0]   ex_rs2;
  logic              ex_pred_taken;
  logic              redirect_ready;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              flush_if;
  logic              flush_id;
  logic              stall_ex;
  logic              link_we;
  logic [XLEN-1:0]   link_data;
  logic              misalign_exc;
  logic [CNT_W-1:0]  mispredict_cnt;

  modport master (
    output ex_valid, ex_pc, ex_opcode, ex_func3, ex_imm, ex_rs1, ex_rs2,
           ex_pred_taken, redirect_ready,
    input  redirect_valid, redirect_pc, flush_if, flush_id, stall_ex,
           link_we, link_data, misalign_exc, mispredict_cnt
  );

  modport slave (
    input  ex_valid, ex_pc, ex_opcode, ex_func3, ex_imm, ex_rs1, ex_rs2,
           ex_pred_taken, redirect_ready,
    output redirect_valid, redirect_pc, flush_if, flush_id, stall_ex,
           link_we, link_data, misalign_exc, mispredict_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Resolves JAL/JALR/branch in EX, checks the fetch prediction and sequences
// the PC redirect handshake plus IF/ID flush window on a mispredict.
module branch_redirect_ctrl #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_redirect_ctrl_if.slave  bus
);

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam int unsigned FCNT_W    = 4;

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t             state;
  logic [FCNT_W-1:0]  flush_cnt;

  logic              is_branch, is_jal, is_jalr, is_jump, is_cf;
  logic              cond, taken, misaligned, mispredict, accept;
  logic [XLEN-1:0]   imm_sext, target, seq_pc, actual_pc;

  // Outcome and target evaluation for the instruction currently in EX
  always_comb begin
    is_branch = (bus.ex_opcode == OP_BRANCH);
    is_jal    = (bus.ex_opcode == OP_JAL);
    is_jalr   = (bus.ex_opcode == OP_JALR);
    is_jump   = is_jal | is_jalr;
    is_cf     = is_branch | is_jump;
    imm_sext  = {{(XLEN-21){bus.ex_imm[20]}}, bus.ex_imm};
    seq_pc    = bus.ex_pc + XLEN'(4);

    cond = 1'b0;
    unique case (bus.ex_func3)
      3'b000:  cond = (bus.ex_rs1 == bus.ex_rs2);
      3'b001:  cond = (bus.ex_rs1 != bus.ex_rs2);
      3'b100:  cond = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
      3'b101:  cond = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
      3'b110:  cond = (bus.ex_rs1 <  bus.ex_rs2);
      3'b111:  cond = (bus.ex_rs1 >= bus.ex_rs2);
      default: cond = 1'b0;
    endcase

    taken      = is_jump | (is_branch & cond);
    target     = is_jalr ? ((bus.ex_rs1 + imm_sext) & ~XLEN'(1))
                         : (bus.ex_pc + imm_sext);
    actual_pc  = taken ? target : seq_pc;
    misaligned = taken & (target[1:0] != 2'b00);
    mispredict = (taken != bus.ex_pred_taken);
    accept     = (state == IDLE) & bus.ex_valid & is_cf;
  end

  assign bus.stall_ex = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      flush_cnt          <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.flush_if       <= 1'b0;
      bus.flush_id       <= 1'b0;
      bus.link_we        <= 1'b0;
      bus.link_data      <= '0;
      bus.misalign_exc   <= 1'b0;
      bus.mispredict_cnt <= '0;
    end else begin
      bus.link_we      <= 1'b0;
      bus.misalign_exc <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (misaligned) begin
              bus.misalign_exc <= 1'b1;
            end else begin
              if (is_jump) begin
                bus.link_we   <= 1'b1;
                bus.link_data <= seq_pc;
              end
              if (mispredict) begin
                state              <= REDIRECT;
                bus.redirect_valid <= 1'b1;
                bus.redirect_pc    <= actual_pc;
                bus.flush_if       <= 1'b1;
                bus.flush_id       <= 1'b1;
                if (bus.mispredict_cnt != {CNT_W{1'b1}})
                  bus.mispredict_cnt <= bus.mispredict_cnt + CNT_W'(1);
              end
            end
          end
        end
        REDIRECT: begin
          if (bus.redirect_ready) begin
            bus.redirect_valid <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state        <= IDLE;
              bus.flush_if <= 1'b0;
              bus.flush_id <= 1'b0;
            end else begin
              state     <= FLUSH;
              flush_cnt <= FCNT_W'(FLUSH_CYCLES - 1);
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state        <= IDLE;
            bus.flush_if <= 1'b0;
            bus.flush_id <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, randomized
// instructions against a reference model, saturation and mid-redirect reset.
module tb_branch_redirect_ctrl;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned FLUSHC = 2;
  localparam int unsigned CNT_W  = 4;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  typedef struct {
    logic        mis;
    logic        link;
    logic [63:0] ldata;
    logic        redir;
    logic [63:0] rpc;
  } exp_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [63:0] pc;
    logic [20:0] imm;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        pred;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  branch_redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSHC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] pc,
                              input logic [20:0] imm, input logic [63:0] rs1, input logic [63:0] rs2,
                              input logic pred, input logic mis, input logic link,
                              input logic [63:0] ldata, input logic redir, input logic [63:0] rpc);
    vec_t v;
    v.op = op; v.f3 = f3; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.pred = pred;
    v.e.mis = mis; v.e.link = link; v.e.ldata = ldata; v.e.redir = redir; v.e.rpc = rpc;
    return v;
  endfunction

  // Architectural reference: what the EX instruction should do, from the ISA rules
  function automatic exp_t model(input vec_t v, input logic valid);
    exp_t r;
    logic [63:0] s, tgt;
    logic taken, jump;
    r = '{mis: 1'b0, link: 1'b0, ldata: 64'd0, redir: 1'b0, rpc: 64'd0};
    jump = (v.op == JAL) || (v.op == JALR);
    if (!valid || !(jump || v.op == BR)) return r;
    s = 64'($signed(v.imm));
    if (jump) taken = 1'b1;
    else if (v.f3 == 3'd0) taken = (v.rs1 == v.rs2);
    else if (v.f3 == 3'd1) taken = (v.rs1 != v.rs2);
    else if (v.f3 == 3'd4) taken = ($signed(v.rs1) < $signed(v.rs2));
    else if (v.f3 == 3'd5) taken = !($signed(v.rs1) < $signed(v.rs2));
    else if (v.f3 == 3'd6) taken = (v.rs1 < v.rs2);
    else if (v.f3 == 3'd7) taken = !(v.rs1 < v.rs2);
    else taken = 1'b0;
    tgt = (v.op == JALR) ? ((v.rs1 + s) & ~64'd1) : (v.pc + s);
    if (taken && (tgt % 4 != 0)) begin
      r.mis = 1'b1;
      return r;
    end
    r.link  = jump;
    r.ldata = v.pc + 64'd4;
    r.redir = (taken != v.pred);
    r.rpc   = taken ? tgt : v.pc + 64'd4;
    return r;
  endfunction

  task automatic drive(input vec_t v, input logic valid);
    bus.ex_valid = valid; bus.ex_opcode = v.op; bus.ex_func3 = v.f3; bus.ex_pc = v.pc;
    bus.ex_imm = v.imm; bus.ex_rs1 = v.rs1; bus.ex_rs2 = v.rs2; bus.ex_pred_taken = v.pred;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    int sel = $urandom_range(0, 3);
    v.op  = (sel == 0) ? BR : (sel == 1) ? JAL : (sel == 2) ? JALR : 7'($urandom);
    v.f3  = 3'($urandom);
    v.pc  = {$urandom, $urandom} & ~64'd3;
    v.imm = 21'($urandom);
    if ($urandom_range(0, 1) == 1) v.imm = v.imm & ~21'd3;
    v.rs1 = {$urandom, $urandom};
    v.rs2 = ($urandom_range(0, 2) == 0) ? v.rs1 : {$urandom, $urandom};
    v.pred = 1'($urandom);
    v.e = '{mis: 1'b0, link: 1'b0, ldata: 64'd0, redir: 1'b0, rpc: 64'd0};
    return v;
  endfunction

  // Present one instruction, then follow any redirect/flush sequence to IDLE
  task automatic issue(input vec_t v, input logic valid, input exp_t e, input int rdelay);
    int n;
    @(negedge clk);
    drive(v, valid);
    bus.redirect_ready = 1'($urandom);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    bus.redirect_ready = 1'b0;
    if (e.redir && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + CNT_W'(1);
    chk("misalign_exc", 64'(bus.misalign_exc), 64'(e.mis));
    chk("link_we", 64'(bus.link_we), 64'(e.link));
    if (e.link) chk("link_data", bus.link_data, e.ldata);
    chk("redirect_valid", 64'(bus.redirect_valid), 64'(e.redir));
    chk("stall_ex", 64'(bus.stall_ex), 64'(e.redir));
    chk("mispredict_cnt", 64'(bus.mispredict_cnt), 64'(exp_cnt));
    if (e.redir) begin
      chk("redirect_pc", bus.redirect_pc, e.rpc);
      chk("flush_if", 64'(bus.flush_if), 64'd1);
      for (int i = 0; i < rdelay; i++) begin
        drive(rand_vec(), 1'b1);
        @(negedge clk);
        chk("wait redirect_valid", 64'(bus.redirect_valid), 64'd1);
        chk("wait redirect_pc", bus.redirect_pc, e.rpc);
        chk("wait stall_ex", 64'(bus.stall_ex), 64'd1);
        chk("wait flush_id", 64'(bus.flush_id), 64'd1);
      end
      bus.ex_valid = 1'b0;
      bus.redirect_ready = 1'b1;
      @(negedge clk);
      bus.redirect_ready = 1'b0;
      chk("post-hs redirect_valid", 64'(bus.redirect_valid), 64'd0);
      n = 0;
      while (bus.stall_ex && n < 40) begin
        chk("flush window flush_if", 64'(bus.flush_if), 64'd1);
        n++;
        @(negedge clk);
      end
      chk("flush cycles", 64'(n), 64'(FLUSHC));
      chk("flush end flush_id", 64'(bus.flush_id), 64'd0);
      chk("end cnt stable", 64'(bus.mispredict_cnt), 64'(exp_cnt));
    end else begin
      @(negedge clk);
      chk("pulse link_we", 64'(bus.link_we), 64'd0);
      chk("pulse misalign", 64'(bus.misalign_exc), 64'd0);
      chk("idle stall_ex", 64'(bus.stall_ex), 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " redirect_valid"}, 64'(bus.redirect_valid), 64'd0);
    chk({tag, " redirect_pc"}, bus.redirect_pc, 64'd0);
    chk({tag, " flush"}, 64'({bus.flush_if, bus.flush_id}), 64'd0);
    chk({tag, " stall_ex"}, 64'(bus.stall_ex), 64'd0);
    chk({tag, " link"}, 64'(bus.link_we) | bus.link_data, 64'd0);
    chk({tag, " misalign_exc"}, 64'(bus.misalign_exc), 64'd0);
    chk({tag, " mispredict_cnt"}, 64'(bus.mispredict_cnt), 64'd0);
  endtask

  vec_t vecs[13];
  vec_t rv;

  initial begin
    vecs[0]  = mk(BR,   3'd0, 64'h1000, 21'h20, 64'd5, 64'd5, 1'b0, 0, 0, 64'h0, 1, 64'h1020);
    vecs[1]  = mk(BR,   3'd4, 64'h1000, 21'h20, '1, 64'd1, 1'b1, 0, 0, 64'h0, 0, 64'h0);
    vecs[2]  = mk(BR,   3'd6, 64'h1000, 21'h20, '1, 64'd1, 1'b1, 0, 0, 64'h0, 1, 64'h1004);
    vecs[3]  = mk(JALR, 3'd0, 64'h500, 21'h4, 64'h2003, 64'd0, 1'b0, 1, 0, 64'h0, 0, 64'h0);
    vecs[4]  = mk(JAL,  3'd0, 64'h800, 21'h1FFFF8, 64'd0, 64'd0, 1'b1, 0, 1, 64'h804, 0, 64'h0);
    vecs[5]  = mk(BR,   3'd0, 64'hFFFF_FFFF_FFFF_FFF0, 21'h20, 64'd7, 64'd7, 1'b0, 0, 0, 64'h0, 1, 64'h10);
    vecs[6]  = mk(BR,   3'd1, 64'h2000, 21'h40, 64'd3, 64'd3, 1'b1, 0, 0, 64'h0, 1, 64'h2004);
    vecs[7]  = mk(BR,   3'd5, 64'h3000, 21'h1FFFF0, -64'sd5, -64'sd5, 1'b0, 0, 0, 64'h0, 1, 64'h2FF0);
    vecs[8]  = mk(BR,   3'd2, 64'h4000, 21'h8, 64'd1, 64'd2, 1'b1, 0, 0, 64'h0, 1, 64'h4004);
    vecs[9]  = mk(JAL,  3'd0, 64'h100, 21'h40, 64'd0, 64'd0, 1'b0, 0, 1, 64'h104, 1, 64'h140);
    vecs[10] = mk(7'b0110011, 3'd0, 64'h900, 21'h8, 64'd1, 64'd1, 1'b1, 0, 0, 64'h0, 0, 64'h0);
    vecs[11] = mk(JALR, 3'd0, 64'h600, 21'h0, 64'h1001, 64'd0, 1'b0, 0, 1, 64'h604, 1, 64'h1000);
    vecs[12] = mk(BR,   3'd7, 64'h700, 21'h10, 64'd1, '1, 1'b0, 0, 0, 64'h0, 0, 64'h0);

    drive(vecs[10], 1'b0);
    bus.redirect_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) issue(vecs[i], 1'b1, vecs[i].e, i % 4);

    for (int k = 0; k < 150; k++) begin
      logic valid;
      rv = rand_vec();
      valid = ($urandom_range(0, 7) != 0);
      issue(rv, valid, model(rv, valid), $urandom_range(0, 3));
    end

    // Drive the counter to saturation, then one more mispredict must hold it
    while (exp_cnt != {CNT_W{1'b1}}) issue(vecs[0], 1'b1, vecs[0].e, 0);
    issue(vecs[5], 1'b1, vecs[5].e, 1);
    chk("saturated cnt", 64'(bus.mispredict_cnt), 64'hF);

    // Reset while a redirect is waiting for ready: the redirect must vanish
    @(negedge clk);
    drive(vecs[6], 1'b1);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    chk("hold redirect_valid", 64'(bus.redirect_valid), 64'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("hold redirect_pc", bus.redirect_pc, 64'h2004);
      chk("hold stall_ex", 64'(bus.stall_ex), 64'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    chk_all_zero("mid reset");
    rst = 1'b0;
    bus.redirect_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("dropped redirect_valid", 64'(bus.redirect_valid), 64'd0);
      chk("dropped stall_ex", 64'(bus.stall_ex), 64'd0);
    end
    bus.redirect_ready = 1'b0;
    issue(vecs[11], 1'b1, vecs[11].e, 2);
    chk("cnt after reset", 64'(bus.mispredict_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
